// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Shared types for the sequential ALU (alu_seq_unit) and its iterative
//   multiply/divide engine (alu_seq_muldiv).
//
//   Contents:
//     alu_op_e       4-bit opcode encoding (RV base integer + M subset).
//     alu_state_e    handshake FSM states IDLE / BUSY / DONE.
//     md_mode_e      engine mode: shift-add multiply or restoring divide.
//     is_multicycle  true for opcodes that are executed by the engine.
//
//   Optional feature macro: ALU_SIGNED_DIV_EN
//     When defined, DIV/REM (13/14) are multi-cycle signed divide ops.
//     When undefined, they behave like the reserved opcode 15.
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_SLT  = 4'd5,
        OP_SLTU = 4'd6,
        OP_SLL  = 4'd7,
        OP_SRL  = 4'd8,
        OP_SRA  = 4'd9,
        OP_MUL  = 4'd10,
        OP_DIVU = 4'd11,
        OP_REMU = 4'd12,
        OP_DIV  = 4'd13,
        OP_REM  = 4'd14,
        OP_RSVD = 4'd15
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } alu_state_e;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_mode_e;

    function automatic logic is_multicycle(alu_op_e op);
        case (op)
            OP_MUL, OP_DIVU, OP_REMU: return 1'b1;
`ifdef ALU_SIGNED_DIV_EN
            OP_DIV, OP_REM:           return 1'b1;
`endif
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// ---------------------------------------------------------------------------
// alu_seq_muldiv
//   Iterative unsigned multiply / divide engine, one bit per clock.
//     MUL : shift-add, low Bits of the product.
//     DIV : restoring division; divide by zero naturally yields
//           quotient = all ones and remainder = dividend.
//   A start pulse loads the operands and sets the counter to Bits; the
//   counter then decrements once per iteration. done_o is high during the
//   final iteration and the result outputs carry that iteration's values,
//   so the caller can register the result on the same edge the counter
//   reaches 0.
//
//   Ports:
//     clk, rst_n     clock, asynchronous active-low reset
//     start_i        load operands and begin (ignored result of any run)
//     mode_i         MD_MUL or MD_DIV
//     a_i, b_i       multiplicand/multiplier or dividend/divisor
//     done_o         final iteration in progress this cycle
//     product_o      low Bits of a*b (valid with done_o)
//     quotient_o     a / b             (valid with done_o)
//     remainder_o    a % b             (valid with done_o)
// ---------------------------------------------------------------------------
module alu_seq_muldiv
    import alu_pkg::*;
#(
    parameter int Bits = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  md_mode_e        mode_i,
    input  logic [Bits-1:0] a_i,
    input  logic [Bits-1:0] b_i,
    output logic            done_o,
    output logic [Bits-1:0] product_o,
    output logic [Bits-1:0] quotient_o,
    output logic [Bits-1:0] remainder_o
);

    localparam int CNT_W = $clog2(Bits + 1);

    logic [CNT_W-1:0] cnt_q;
    md_mode_e         mode_q;
    // x: multiplicand (MUL) or dividend shifting into quotient (DIV)
    // y: multiplier (MUL) or divisor (DIV)
    // acc: product accumulator (MUL) or partial remainder (DIV)
    logic [Bits-1:0]  x_q, x_d;
    logic [Bits-1:0]  y_q, y_d;
    logic [Bits-1:0]  acc_q, acc_d;
    logic [Bits:0]    shifted;

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        shifted = {acc_q, x_q[Bits-1]};
        if (mode_q == MD_MUL) begin
            if (y_q[0]) begin
                acc_d = acc_q + x_q;
            end
            x_d = x_q << 1;
            y_d = y_q >> 1;
        end else begin
            // Trial subtract on the widened partial remainder; the result
            // fits Bits whenever the subtraction is taken.
            if (shifted >= {1'b0, y_q}) begin
                acc_d = Bits'(shifted - {1'b0, y_q});
                x_d   = {x_q[Bits-2:0], 1'b1};
            end else begin
                acc_d = shifted[Bits-1:0];
                x_d   = {x_q[Bits-2:0], 1'b0};
            end
        end
    end

    // NOTE: state uses non-blocking assignments in an always_ff with the
    // asynchronous active-low reset in the sensitivity list.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            mode_q <= MD_MUL;
            x_q    <= '0;
            y_q    <= '0;
            acc_q  <= '0;
        end else if (start_i) begin
            cnt_q  <= CNT_W'(Bits);
            mode_q <= mode_i;
            x_q    <= a_i;
            y_q    <= b_i;
            acc_q  <= '0;
        end else if (cnt_q != '0) begin
            cnt_q  <= cnt_q - CNT_W'(1);
            x_q    <= x_d;
            y_q    <= y_d;
            acc_q  <= acc_d;
        end
    end

    assign done_o      = (cnt_q == CNT_W'(1));
    assign product_o   = acc_d;
    assign quotient_o  = x_d;
    assign remainder_o = acc_d;

endmodule

// File: rtl/alu_seq_unit.sv
// ---------------------------------------------------------------------------
// alu_seq_unit
//   Sequential RISC-V integer ALU with valid/ready handshake on both sides.
//   Single-cycle ops (ADD..SRA, reserved) complete one cycle after accept;
//   MUL/DIVU/REMU (and DIV/REM when enabled) run on alu_seq_muldiv and
//   complete Bits+1 cycles after accept. Results and the zero flag are
//   registered and held until the consumer retires them.
//
//   Ports:
//     clk, rst_n   clock, asynchronous active-low reset
//     in_valid     request present          in_ready   request accepted
//     op, A, B     opcode and operands, captured on accept
//     out_valid    result present           out_ready  result consumed
//     resultado    registered result        zero       resultado == 0
//
//   Optional feature macro: ALU_SIGNED_DIV_EN
//     Defined  : DIV/REM are signed; the engine divides magnitudes and the
//                signs are corrected here on completion.
//     Undefined: DIV/REM behave as the reserved opcode (result 0, zero 1).
// ---------------------------------------------------------------------------
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int Bits = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      op,
    input  logic [Bits-1:0] A,
    input  logic [Bits-1:0] B,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [Bits-1:0] resultado,
    output logic            zero
);

    localparam int SHAMT_W = $clog2(Bits);

    alu_state_e      state_q, state_d;
    alu_op_e         op_q, op_d;
    logic [Bits-1:0] res_q, res_d;
    logic            zero_q, zero_d;

    alu_op_e         op_in;
    logic            accept;
    logic            multi_in;
    logic [Bits-1:0] single_res;
    logic [Bits-1:0] md_res;
    logic [Bits-1:0] md_a, md_b;
    logic            md_start;
    md_mode_e        md_mode;
    logic            md_done;
    logic [Bits-1:0] md_product, md_quotient, md_remainder;
    logic [SHAMT_W-1:0] shamt;

    assign op_in    = alu_op_e'(op);
    assign in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    assign accept   = in_valid && in_ready;
    assign multi_in = is_multicycle(op_in);
    assign md_mode  = (op_in == OP_MUL) ? MD_MUL : MD_DIV;
    assign shamt    = B[SHAMT_W-1:0];

    always_comb begin
        single_res = '0;
        case (op_in)
            OP_ADD:  single_res = A + B;
            OP_SUB:  single_res = A - B;
            OP_AND:  single_res = A & B;
            OP_OR:   single_res = A | B;
            OP_XOR:  single_res = A ^ B;
            OP_SLT:  single_res = {{(Bits-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SLTU: single_res = {{(Bits-1){1'b0}}, (A < B)};
            OP_SLL:  single_res = A << shamt;
            OP_SRL:  single_res = A >> shamt;
            OP_SRA:  single_res = $signed(A) >>> shamt;
            default: single_res = '0;
        endcase
    end

`ifdef ALU_SIGNED_DIV_EN
    // Signed divide: the engine sees magnitudes. The quotient is negated
    // when the operand signs differ, except for divide by zero where the
    // all-ones quotient must pass through untouched. The remainder follows
    // the sign of A, which also reproduces remainder = A for B = 0.
    logic signed_in;
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;

    assign signed_in = (op_in == OP_DIV) || (op_in == OP_REM);
    assign md_a      = (signed_in && A[Bits-1]) ? -A : A;
    assign md_b      = (signed_in && B[Bits-1]) ? -B : B;
    assign neg_quo_d = accept ? (signed_in && (A[Bits-1] ^ B[Bits-1]) && (B != '0))
                              : neg_quo_q;
    assign neg_rem_d = accept ? (signed_in && A[Bits-1]) : neg_rem_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end
`else
    assign md_a = A;
    assign md_b = B;
`endif

    always_comb begin
        md_res = '0;
        case (op_q)
            OP_MUL:  md_res = md_product;
            OP_DIVU: md_res = md_quotient;
            OP_REMU: md_res = md_remainder;
`ifdef ALU_SIGNED_DIV_EN
            OP_DIV:  md_res = neg_quo_q ? -md_quotient  : md_quotient;
            OP_REM:  md_res = neg_rem_q ? -md_remainder : md_remainder;
`endif
            default: md_res = '0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        res_d    = res_q;
        zero_d   = zero_q;
        md_start = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (accept) begin
                    // In DONE an accept implies out_ready, so the held
                    // result retires on this same edge.
                    op_d = op_in;
                    if (multi_in) begin
                        state_d  = BUSY;
                        md_start = 1'b1;
                    end else begin
                        state_d = DONE;
                        res_d   = single_res;
                        zero_d  = (single_res == '0);
                    end
                end else if ((state_q == DONE) && out_ready) begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (md_done) begin
                    state_d = DONE;
                    res_d   = md_res;
                    zero_d  = (md_res == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= OP_ADD;
            res_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
        end
    end

    alu_seq_muldiv #(.Bits(Bits)) u_muldiv (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_i     (md_start),
        .mode_i      (md_mode),
        .a_i         (md_a),
        .b_i         (md_b),
        .done_o      (md_done),
        .product_o   (md_product),
        .quotient_o  (md_quotient),
        .remainder_o (md_remainder)
    );

    assign out_valid = (state_q == DONE);
    assign resultado = res_q;
    assign zero      = zero_q;

endmodule
